// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - partial-sum accumulator with length-configured termination (optional output ReLU via PSUM_ACC_RELU_EN)
module psum_acc #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 32,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LWIDTH-1:0] cfg_len,
    input  logic [DWIDTH-1:0] psum_in,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [AWIDTH-1:0] acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] acc;
    logic [AWIDTH-1:0] ext;
    logic [AWIDTH-1:0] sum;
    logic [AWIDTH-1:0] result;
    logic [LWIDTH-1:0] cnt;
    logic [LWIDTH-1:0] len;
    logic              beat;
    logic              last;

    assign ext  = AWIDTH'($signed(psum_in));
    assign sum  = acc + ext;
    assign beat = psum_valid && (state == ACC);
    assign last = beat && (cnt == len);

`ifdef PSUM_ACC_RELU_EN
    // Clamp only the published value; the running accumulator keeps the raw sum.
    assign result = sum[AWIDTH-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    assign psum_ready = (state == ACC);
    assign acc_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = ACC;
            ACC:     if (last)      state_next = DONE;
            DONE:    if (acc_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len     <= '0;
            acc_out <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start) begin
                len <= cfg_len;
                acc <= '0;
                cnt <= '0;
            end
            if (beat) begin
                acc <= sum;
                cnt <= cnt + LWIDTH'(1);
            end
            if (last) begin
                acc_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - randomized and directed checks of psum_acc against a sum-of-terms model
module tb_psum_acc;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic [DW-1:0] psum_in;
    logic          psum_valid;
    logic          psum_ready;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int beats[$];

    psum_acc #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cfg_len   (cfg_len),
        .psum_in   (psum_in),
        .psum_valid(psum_valid),
        .psum_ready(psum_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected result: plain sum of the terms, wrapped to AW bits, optionally clamped.
    function automatic longint model_result();
        longint s = 0;
        longint r;
        foreach (beats[i]) s += beats[i];
        r = s % (64'sd1 <<< AW);
        if (r >= (64'sd1 <<< (AW - 1))) r -= (64'sd1 <<< AW);
        if (r < -(64'sd1 <<< (AW - 1))) r += (64'sd1 <<< AW);
`ifdef PSUM_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic longint out_s();
        return longint'($signed(acc_out));
    endfunction

    // Called #1 after a rising edge with the DUT idle; runs one full operation.
    task automatic run_op(input string tag, input int gap_lo, input int gap_hi, input int stall, input bit noise);
        longint exp;
        int     gap;
        exp = model_result();
        start   = 1'b1;
        cfg_len = LW'(beats.size() - 1);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_acc"}, busy, 1);
        check({tag, "_ready_acc"}, psum_ready, 1);
        foreach (beats[i]) begin
            gap = $urandom_range(gap_hi, gap_lo);
            repeat (gap) begin
                psum_valid = 1'b0;
                psum_in    = DW'($urandom);
                if (noise) begin
                    start   = 1'b1;
                    cfg_len = LW'($urandom);
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            check({tag, "_early_valid"}, acc_valid, 0);
            psum_valid = 1'b1;
            psum_in    = DW'(beats[i]);
            if (noise) begin
                start   = 1'b1;
                cfg_len = LW'($urandom);
            end
            @(posedge clk); #1;
            psum_valid = 1'b0;
            start      = 1'b0;
        end
        check({tag, "_valid"}, acc_valid, 1);
        check({tag, "_out"}, out_s(), exp);
        check({tag, "_ready_done"}, psum_ready, 0);
        check({tag, "_busy_done"}, busy, 1);
        repeat (stall) begin
            if (noise) begin
                psum_valid = 1'b1;
                psum_in    = DW'($urandom);
                start      = 1'b1;
            end
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, acc_valid, 1);
            check({tag, "_stall_out"}, out_s(), exp);
        end
        acc_ready = 1'b1;
        start     = noise;
        @(posedge clk); #1;
        acc_ready  = 1'b0;
        start      = 1'b0;
        psum_valid = 1'b0;
        check({tag, "_drop_valid"}, acc_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ready"}, psum_ready, 0);
        @(posedge clk); #1;
        check({tag, "_still_idle"}, busy, 0);
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        cfg_len    = '0;
        psum_in    = '0;
        psum_valid = 1'b0;
        acc_ready  = 1'b0;
        #2;
        check("rst_ready", psum_ready, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out_s(), 0);
        #20 rstn = 1'b1;
        @(posedge clk); #1;

        beats = '{10, -4, 7, 100};
        run_op("basic", 0, 0, 0, 0);

        beats = '{-300, -200};
        run_op("bubble", 3, 3, 5, 0);

        beats = '{32767};
        run_op("single", 0, 0, 1, 0);

        beats.delete();
        repeat (256) beats.push_back(-32768);
        run_op("maxlen", 0, 0, 0, 0);

        // Beats offered while idle must be dropped.
        psum_valid = 1'b1;
        psum_in    = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        psum_valid = 1'b0;
        check("idle_drop_busy", busy, 0);
        beats = '{1000, -2000, 3, 4, 5};
        run_op("noise", 0, 2, 3, 1);

        // Reset in the middle of an operation.
        start   = 1'b1;
        cfg_len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psum_valid = 1'b1;
            psum_in    = 16'd50;
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_ready", psum_ready, 0);
        check("mid_rst_valid", acc_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out", out_s(), 0);
        #2 rstn = 1'b1;
        beats = '{5, 6};
        run_op("after_rst", 0, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            int len;
            len = $urandom_range(15, 0);
            beats.delete();
            for (int k = 0; k <= len; k++) beats.push_back(int'($urandom_range(65535, 0)) - 32768);
            run_op("rand", 0, 2, $urandom_range(3, 0), n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
